// File: rtl/cla_subtractor_pipe.sv
// Pipelined D = A - B - Bin (computed as A + ~B + ~Bin), one CHUNK-bit lookahead slice per stage.
// Optional signed-overflow output V is enabled by defining CLA_SUB_OVERFLOW_EN.

module cla_sub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK-1:0] p, g;
    logic [CHUNK:0]   c;

    assign p = a ^ ~b;
    assign g = a & ~b;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign s  = p ^ c[CHUNK-1:0];
    assign co = c[CHUNK];
endmodule

module cla_subtractor_pipe #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
`ifdef CLA_SUB_OVERFLOW_EN
    output logic         V,
`endif
    output logic         Bout
);
    // N must be a multiple of CHUNK; register k holds the state after slice k has resolved.
    localparam int STAGES = N / CHUNK;

    logic                          adv;
    logic [STAGES-1:0]             vld_pipe;
    logic [N-1:0]                  a_r [STAGES];
    logic [N-1:0]                  b_r [STAGES];
    logic [N-1:0]                  d_r [STAGES];
    logic                          c_r [STAGES];
    logic                          bout_q;

    logic [STAGES-1:0][N-1:0]      si_a, si_b, si_d, nxt_d;
    logic [STAGES-1:0]             si_c, si_v, sl_co;
    logic [STAGES-1:0][CHUNK-1:0]  sl_s;

    assign adv       = ~vld_pipe[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];
    assign D         = d_r[STAGES-1];
    assign Bout      = bout_q;

    // Slice inputs: stage 0 works straight off the operands, later stages off the previous register.
    always_comb begin
        si_a[0] = A;
        si_b[0] = B;
        si_d[0] = '0;
        si_c[0] = ~Bin;
        si_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            si_a[k] = a_r[k-1];
            si_b[k] = b_r[k-1];
            si_d[k] = d_r[k-1];
            si_c[k] = c_r[k-1];
            si_v[k] = vld_pipe[k-1];
        end
    end

    always_comb begin
        nxt_d = si_d;
        for (int k = 0; k < STAGES; k++) nxt_d[k][k*CHUNK +: CHUNK] = sl_s[k];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_sub_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (si_a[k][k*CHUNK +: CHUNK]),
            .b  (si_b[k][k*CHUNK +: CHUNK]),
            .ci (si_c[k]),
            .s  (sl_s[k]),
            .co (sl_co[k])
        );
    end

`ifdef CLA_SUB_OVERFLOW_EN
    logic v_q;
    assign V = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= 1'b0;
        else if (adv)
            v_q <= (si_a[STAGES-1][N-1] ^ si_b[STAGES-1][N-1]) &
                   (si_a[STAGES-1][N-1] ^ nxt_d[STAGES-1][N-1]);
    end
`endif

    // One shared enable: the whole pipe either shifts or holds, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            bout_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                d_r[k] <= '0;
                c_r[k] <= 1'b0;
            end
        end else if (adv) begin
            vld_pipe <= si_v;
            bout_q   <= ~sl_co[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= si_a[k];
                b_r[k] <= si_b[k];
                d_r[k] <= nxt_d[k];
                c_r[k] <= sl_co[k];
            end
        end
    end
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Directed bench for cla_subtractor_pipe: vector table, backpressure stream, mid-stream reset.
// Build with CLA_SUB_OVERFLOW_EN defined to also check V.

module tb_cla_subtractor_pipe;
    localparam int N = 32, CHUNK = 8, STAGES = N / CHUNK;

    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, Bin = 0;
    logic [N-1:0] A = '0, B = '0;
    logic         in_ready, out_valid, Bout;
    logic [N-1:0] D;
`ifdef CLA_SUB_OVERFLOW_EN
    logic         V;
`endif

    cla_subtractor_pipe #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .D(D),
`ifdef CLA_SUB_OVERFLOW_EN
        .V(V),
`endif
        .Bout(Bout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] a, b;
        logic         bin;
        logic [N-1:0] d;
        logic         bout;
        logic         v;
    } vec_t;
    vec_t vt[11];

    task automatic run_one(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        A = v.a; B = v.b; Bin = v.bin; in_valid = 1; out_ready = 1;
        #1 chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, STAGES - 1);
        chk($sformatf("v%0d_D", idx), D, v.d);
        chk($sformatf("v%0d_Bout", idx), Bout, v.bout);
`ifdef CLA_SUB_OVERFLOW_EN
        chk($sformatf("v%0d_V", idx), V, v.v);
`endif
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, b, input logic bin);
        model = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] ra[10], rb[10];
        logic         rbin[10];
        logic [N:0]   exp_q[$];
        logic [N:0]   e;
        logic [N-1:0] held_d;
        logic         held_b, was_stall;
        int           sent, got, seen;

        vt[0]  = '{32'd4755,      32'd1349,      1'b0, 32'd3406,      1'b0, 1'b0};
        vt[1]  = '{32'd1349,      32'd4755,      1'b0, 32'hFFFFF2B2,  1'b1, 1'b0};
        vt[2]  = '{32'h0,         32'h0,         1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
        vt[3]  = '{32'h00000100,  32'h00000001,  1'b0, 32'h000000FF,  1'b0, 1'b0};
        vt[4]  = '{32'h01000000,  32'h00000001,  1'b0, 32'h00FFFFFF,  1'b0, 1'b0};
        vt[5]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h0,         1'b0, 1'b0};
        vt[6]  = '{32'hFFFFFFFF,  32'h0,         1'b1, 32'hFFFFFFFE,  1'b0, 1'b0};
        vt[7]  = '{32'h80000000,  32'h00000001,  1'b0, 32'h7FFFFFFF,  1'b0, 1'b1};
        vt[8]  = '{32'd5,         32'd3,         1'b0, 32'd2,         1'b0, 1'b0};
        vt[9]  = '{32'd3,         32'd5,         1'b1, 32'hFFFFFFFD,  1'b1, 1'b0};
        vt[10] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h80000000,  1'b1, 1'b1};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_D", D, 0);
        chk("rst_Bout", Bout, 0);
        @(posedge clk); #1 rst_n = 1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 11; i++) run_one(vt[i], i);
        @(posedge clk); #1;

        // backpressure stream
        for (int i = 0; i < 10; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rbin[i] = 1'($urandom_range(0, 1));
        end
        ra[0] = 32'h0; rb[0] = 32'h1;
        sent = 0; got = 0; was_stall = 0; held_d = '0; held_b = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (sent < 10) begin
                A = ra[sent]; B = rb[sent]; Bin = rbin[sent]; in_valid = 1;
            end else in_valid = 0;
            #1;
            if (out_valid && !out_ready) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, 0);
                if (was_stall) begin
                    chk($sformatf("bp_hold_D_c%0d", cyc), D, held_d);
                    chk($sformatf("bp_hold_Bout_c%0d", cyc), Bout, held_b);
                end
                held_d = D; held_b = Bout; was_stall = 1;
            end else was_stall = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bp_D_%0d", got), D, e[N-1:0]);
                    chk($sformatf("bp_Bout_%0d", got), Bout, e[N]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ra[sent], rb[sent], rbin[sent]));
                sent++;
            end
        end
        chk("bp_count", got, 10);
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;

        // reset with 3 operations in flight, the oldest stalled at the output
        for (int i = 0; i < 3; i++) begin
            A = 32'(i + 1); B = 32'(i + 2); Bin = 0; in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        chk("mr_pre_out_valid", out_valid, 1);
        chk("mr_pre_D", D, 32'hFFFFFFFF);
        chk("mr_pre_Bout", Bout, 1);
        #2 rst_n = 0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_D", D, 0);
        chk("mr_Bout", Bout, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        #1;
        chk("mr_in_ready", in_ready, 1);
        out_ready = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mr_no_ghost", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cla_subtractor_pipe.md
# cla_subtractor_pipe

Pipelined N-bit subtractor computing D = A − B − Bin with borrow-out. It is the inverse-operation companion to the team's combinational N-bit carry-lookahead adder. Internally it forms A + ~B + ~Bin, with the lookahead carry chain split into CHUNK-bit slices, one slice per pipeline stage. It sits on a valid/ready stream with full backpressure, so it can be dropped between registered datapath blocks without closing N-bit carry timing in one cycle.

## Interface
- N, default 32: operand/result width; must be an integer multiple of CHUNK.
- CHUNK, default 8: bits resolved per pipeline stage; STAGES = N/CHUNK.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active low.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 0 can accept.
- A  input  N  minuend, unsigned or two's complement.
- B  input  N  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- D  output  N  difference.
- Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
- V  output  1  signed overflow; present only with CLA_SUB_OVERFLOW_EN.

## Operation
- Stage k (0..STAGES-1) holds:
  - a valid bit;
  - the completed low difference bits [k·CHUNK−1:0];
  - the unprocessed A/B bits above those;
  - the carry into slice k.
- Stage 0 carry-in is ~Bin.
- Each stage computes for its slice P = a ^ ~b and G = a & ~b, with lookahead carries c[i+1] = G[i] | P[i]&c[i]. Slice difference = P ^ c.
- Each stage passes its slice's carry-out to stage k+1.
- After the last stage:
  - D = all assembled slices;
  - Bout = ~carry-out of the top slice.
- Widths: no truncation except modulo 2^N wrap. For example, 0 − 1 gives D = all-ones, Bout = 1.
- Advance enable: adv = ~out_valid | out_ready.
  - When adv = 1, every stage shifts forward one position, and stage 0 captures {in_valid, operands}.
  - When adv = 0, all stages hold, including bubbles. No internal bubble compression.
- in_ready = adv. A transfer occurs on in_valid & in_ready. Operands are sampled only on a transfer.
- Output transfer occurs on out_valid & out_ready. D, Bout and V are stable while out_valid = 1 and out_ready = 0.
- Results leave in acceptance order; no reordering or dropping.
- Reset (asynchronous, any time, including mid-stream):
  - all valid bits clear;
  - D = 0, Bout = 0, V = 0;
  - in-flight operations are discarded;
  - in_ready = 1 once reset deasserts.

## Timing
- Latency: a result accepted at edge t is presented on out_valid after edge t+STAGES−1. The final stage output is registered; no comb path from A/B to D.
- Throughput: one result per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready and the last-stage valid bit. No other comb input-to-output path exists.
- Simultaneous in and out transfer in the same cycle is legal and required at full rate.
- STAGES = 1 degenerates to a single registered stage, latency 1.

## Configuration
- CLA_SUB_OVERFLOW_EN defined:
  - V port exists;
  - V = (A[N−1] ^ B[N−1]) & (A[N−1] ^ D[N−1]), with the A and B sign bits carried down the pipeline;
  - V is registered alongside D and resets to 0.
- Undefined: V port and its pipeline bits are absent; all other behaviour is identical.

## Test plan
- Basic, N=32, CHUNK=8: A=4755, B=1349, Bin=0 → after 4 cycles D=3406, Bout=0.
- Borrow/wrap: A=1349, B=4755, Bin=0 → D=4294963890 (0xFFFFF2B2), Bout=1. A=0, B=0, Bin=1 → D=0xFFFFFFFF, Bout=1.
- Cross-slice carry: A=0x00000100, B=0x00000001, Bin=0 → D=0x000000FF, Bout=0, exercising borrow propagation across the slice 0/1 boundary.
- Backpressure:
  - stream 10 back-to-back random operand pairs, holding out_ready=0 for cycles 5–8;
  - in_ready must drop while out_valid & ~out_ready;
  - outputs must be held stable while stalled;
  - all 10 results must appear in order and match a behavioural model A−B−Bin.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight → out_valid=0, D=0, Bout=0 immediately (asynchronously). None of the 3 results appear after release; in_ready=1.
- Overflow (macro defined): A=0x80000000, B=1, Bin=0 → D=0x7FFFFFFF, V=1, Bout=0. A=5, B=3 → V=0.
